scoreboard_fwd: RTL and testbench

- Parametrised hazard and forwarding scoreboard for the MIPS pipeline.
- Sits between decode and execute, replacing hand-coded per-register 2-bit state.
- Tracks in-flight destination registers across DEPTH post-issue stages, selects the forwarding source per operand, and raises stall for load-use hazards.
- Also takes a flush from jump/beq resolution.

---
 rtl/scoreboard_fwd.sv | 133 +++++++++++++
 tb/tb_scoreboard_fwd.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_fwd.sv
// Hazard/forwarding scoreboard between decode and execute: tracks in-flight destinations,
// picks forward sources per operand, stalls on load-use. Optional counters: SCOREBOARD_FWD_STATS_EN.
module scoreboard_fwd_opnd #(
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int READY_ALU  = 1,
  parameter int READY_LOAD = 2,
  parameter int SW         = 2
) (
  input  logic [DEPTH:1]         slot_vld,
  input  logic [DEPTH:1][AW-1:0] slot_dest,
  input  logic [DEPTH:1]         slot_ld,
  input  logic [AW-1:0]          idx,
  input  logic                   used,
  output logic [SW-1:0]          sel,
  output logic                   not_ready
);
  int   hit_k;
  logic hit_ld;

  always_comb begin
    sel       = '0;
    not_ready = 1'b0;
    hit_k     = 0;
    hit_ld    = 1'b0;
    // Walk oldest to youngest so the youngest producer overwrites.
    for (int k = DEPTH; k >= 1; k--) begin
      if (slot_vld[k] && slot_dest[k] == idx) begin
        hit_k  = k;
        hit_ld = slot_ld[k];
      end
    end
    if (used && idx != '0 && hit_k != 0) begin
      if (hit_k >= (hit_ld ? READY_LOAD : READY_ALU)) sel = SW'(hit_k);
      else                                             not_ready = 1'b1;
    end
  end
endmodule

module scoreboard_fwd #(
  parameter int NREGS      = 32,
  parameter int AW         = 5,
  parameter int DEPTH      = 3,
  parameter int READY_ALU  = 1,
  parameter int READY_LOAD = 2,
  parameter int SW         = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_writes,
  input  logic             issue_is_load,
  input  logic [AW-1:0]    issue_dest,
  input  logic [AW-1:0]    src1,
  input  logic [AW-1:0]    src2,
  input  logic             src1_used,
  input  logic             src2_used,
  input  logic             flush,
  output logic             stall,
  output logic [SW-1:0]    fwd_sel1,
  output logic [SW-1:0]    fwd_sel2,
  output logic [NREGS-1:0] busy
`ifdef SCOREBOARD_FWD_STATS_EN
  ,
  output logic [15:0]      stall_count,
  output logic [15:0]      fwd_count,
  output logic [15:0]      flush_count
`endif
);
  logic [DEPTH:1]           slot_vld;
  logic [DEPTH:1]           slot_ld;
  logic [DEPTH:1][AW-1:0]   slot_dest;
  logic [1:0][AW-1:0]       op_idx;
  logic [1:0]               op_used;
  logic [1:0][SW-1:0]       op_sel;
  logic [1:0]               op_nr;

  assign op_idx  = {src2, src1};
  assign op_used = {src2_used, src1_used};

  for (genvar g = 0; g < 2; g++) begin : g_op
    scoreboard_fwd_opnd #(
      .AW(AW), .DEPTH(DEPTH), .READY_ALU(READY_ALU), .READY_LOAD(READY_LOAD), .SW(SW)
    ) u_op (
      .slot_vld(slot_vld), .slot_dest(slot_dest), .slot_ld(slot_ld),
      .idx(op_idx[g]), .used(op_used[g]), .sel(op_sel[g]), .not_ready(op_nr[g])
    );
  end

  assign stall    = issue_valid & ~flush & (|op_nr);
  assign fwd_sel1 = op_sel[0];
  assign fwd_sel2 = op_sel[1];

  always_comb begin
    busy = '0;
    for (int k = 1; k <= DEPTH; k++)
      if (slot_vld[k] && int'(slot_dest[k]) < NREGS) busy[slot_dest[k]] = 1'b1;
    busy[0] = 1'b0;
  end

  // Flush kills both the decode instruction and the one leaving execute.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_vld  <= '0;
      slot_ld   <= '0;
      slot_dest <= '0;
    end else begin
      slot_vld[1]  <= issue_valid & issue_writes & (issue_dest != '0) & ~stall & ~flush;
      slot_dest[1] <= issue_dest;
      slot_ld[1]   <= issue_is_load;
      for (int k = 2; k <= DEPTH; k++) begin
        slot_vld[k]  <= slot_vld[k-1] & ~(flush && k == 2);
        slot_dest[k] <= slot_dest[k-1];
        slot_ld[k]   <= slot_ld[k-1];
      end
    end
  end

`ifdef SCOREBOARD_FWD_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      fwd_count   <= '0;
      flush_count <= '0;
    end else begin
      if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      if ((fwd_sel1 != '0 || fwd_sel2 != '0) && !stall && fwd_count != 16'hFFFF)
        fwd_count <= fwd_count + 16'd1;
      if (flush && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_scoreboard_fwd.sv
// Bench for scoreboard_fwd: queue-of-in-flight-instructions model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_scoreboard_fwd;
  localparam int NREGS = 32, AW = 5, DEPTH = 3, RA = 1, RL = 2, SW = 2;

  logic clock = 1'b0, reset = 1'b1;
  logic issue_valid = 0, issue_writes = 0, issue_is_load = 0, flush = 0;
  logic src1_used = 0, src2_used = 0;
  logic [AW-1:0] issue_dest = '0, src1 = '0, src2 = '0;
  logic stall;
  logic [SW-1:0] fwd_sel1, fwd_sel2;
  logic [NREGS-1:0] busy;
`ifdef SCOREBOARD_FWD_STATS_EN
  logic [15:0] stall_count, fwd_count, flush_count;
  int m_stall_cnt = 0, m_fwd_cnt = 0, m_flush_cnt = 0;
`endif

  always #5 clock = ~clock;

  scoreboard_fwd #(.NREGS(NREGS), .AW(AW), .DEPTH(DEPTH), .READY_ALU(RA),
                   .READY_LOAD(RL), .SW(SW)) dut (
    .clock(clock), .reset(reset), .issue_valid(issue_valid), .issue_writes(issue_writes),
    .issue_is_load(issue_is_load), .issue_dest(issue_dest), .src1(src1), .src2(src2),
    .src1_used(src1_used), .src2_used(src2_used), .flush(flush), .stall(stall),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .busy(busy)
`ifdef SCOREBOARD_FWD_STATS_EN
    , .stall_count(stall_count), .fwd_count(fwd_count), .flush_count(flush_count)
`endif
  );

  // In-flight instruction list: age = cycles since issue.
  typedef struct { logic [AW-1:0] dest; bit ld; int age; } ent_t;
  ent_t q[$];
  ent_t nq[$];
  int n_tot = 0, n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic void op_eval(input logic [AW-1:0] idx, input bit used,
                                  output int sel, output bit nr);
    int best;
    bit bl;
    best = DEPTH + 1;
    bl = 0;
    sel = 0;
    nr = 0;
    if (!used || idx == 0) return;
    foreach (q[i]) if (q[i].dest == idx && q[i].age < best) begin best = q[i].age; bl = q[i].ld; end
    if (best > DEPTH) return;
    if (best >= (bl ? RL : RA)) sel = best;
    else nr = 1;
  endfunction

  function automatic void model(output bit st, output int s1, output int s2,
                                output logic [NREGS-1:0] bz);
    bit n1, n2;
    op_eval(src1, src1_used, s1, n1);
    op_eval(src2, src2_used, s2, n2);
    st = issue_valid && !flush && (n1 || n2);
    bz = '0;
    foreach (q[i]) bz[q[i].dest] = 1'b1;
  endfunction

  bit m_st, c_st;
  int m_s1, m_s2, c_s1, c_s2;
  logic [NREGS-1:0] m_bz, c_bz;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      q.delete();
`ifdef SCOREBOARD_FWD_STATS_EN
      m_stall_cnt = 0; m_fwd_cnt = 0; m_flush_cnt = 0;
`endif
    end else begin
      model(m_st, m_s1, m_s2, m_bz);
`ifdef SCOREBOARD_FWD_STATS_EN
      if (m_st) m_stall_cnt++;
      if ((m_s1 != 0 || m_s2 != 0) && !m_st) m_fwd_cnt++;
      if (flush) m_flush_cnt++;
`endif
      nq.delete();
      foreach (q[i]) begin
        ent_t e;
        e = q[i];
        if (!(flush && e.age == 1)) begin
          e.age++;
          if (e.age <= DEPTH) nq.push_back(e);
        end
      end
      if (issue_valid && issue_writes && issue_dest != 0 && !m_st && !flush)
        nq.push_back('{issue_dest, issue_is_load, 1});
      q = nq;
    end
  end

  always @(negedge clock) begin
    model(c_st, c_s1, c_s2, c_bz);
    chk("stall", stall, c_st);
    chk("fwd_sel1", fwd_sel1, c_s1);
    chk("fwd_sel2", fwd_sel2, c_s2);
    chk("busy", busy, c_bz);
`ifdef SCOREBOARD_FWD_STATS_EN
    chk("stall_count", stall_count, m_stall_cnt);
    chk("fwd_count", fwd_count, m_fwd_cnt);
    chk("flush_count", flush_count, m_flush_cnt);
`endif
  end

  task automatic drive(input bit v, input bit w, input bit ld, input int d,
                       input int a, input bit ua, input int b, input bit ub, input bit fl);
    @(posedge clock);
    #1;
    issue_valid = v; issue_writes = w; issue_is_load = ld; issue_dest = AW'(d);
    src1 = AW'(a); src1_used = ua; src2 = AW'(b); src2_used = ub; flush = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_busy", busy, 0);
    @(posedge clock); #1 reset = 1'b0;

    // ALU producer forwards from slot 1, then slot 2
    drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 8, 3, 1, 0, 0, 0); #2;
    chk("alu_stall", stall, 0);
    chk("alu_sel1_k1", fwd_sel1, 1);
    drive(1, 0, 0, 0, 3, 1, 0, 0, 0); #2;
    chk("alu_sel1_k2", fwd_sel1, 2);
    idle(3);

    // load-use: one stall, then forward from slot 2
    drive(1, 1, 1, 5, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 9, 0, 0, 5, 1, 0); #2;
    chk("lu_stall", stall, 1);
    chk("lu_sel2_0", fwd_sel2, 0);
    drive(1, 1, 0, 9, 0, 0, 5, 1, 0); #2;
    chk("lu_stall_clr", stall, 0);
    chk("lu_sel2_2", fwd_sel2, 2);
    idle(3);

    // youngest producer wins
    drive(1, 1, 0, 4, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 4, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 4, 1, 0, 0, 0); #2;
    chk("young_sel1", fwd_sel1, 1);

    // r0 never tracked
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1, 0, 1, 0); #2;
    chk("r0_sel1", fwd_sel1, 0);
    chk("r0_stall", stall, 0);
    chk("r0_busy0", busy[0], 0);
    idle(3);

    // flush squashes the producer in execute
    drive(1, 1, 0, 7, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #2;
    chk("fl_stall", stall, 0);
    idle(1);
    drive(1, 0, 0, 0, 7, 1, 0, 0, 0); #2;
    chk("fl_sel1", fwd_sel1, 0);
    chk("fl_busy7", busy[7], 0);
`ifdef SCOREBOARD_FWD_STATS_EN
    chk("fl_count", flush_count, 1);
`endif
    idle(3);

    // async reset in the middle of a load-use stall
    drive(1, 1, 0, 3, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 5, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 7, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 9, 7, 1, 5, 1, 0); #2;
    chk("pre_rst_stall", stall, 1);
    chk("pre_rst_busy", busy, 32'h0000_00A8);
    reset = 1'b1; #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_sel1", fwd_sel1, 0);
    chk("mid_rst_sel2", fwd_sel2, 0);
    idle(1);
    reset = 1'b0;
    drive(1, 1, 0, 6, 3, 1, 7, 1, 0); #2;
    chk("post_rst_sel1", fwd_sel1, 0);
    chk("post_rst_stall", stall, 0);

    // randomized traffic over a small register set to force hazards
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
